// File: rtl/quad_decoder.sv
// Quadrature front end: synchronizes and debounces encoder channels A/B,
// decodes Gray-code phase steps and emits one-cycle event codes.
// Optional feature macro: QUAD_ERR_STICKY_EN (builds the sticky error flag).
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   a_in, b_in   asynchronous encoder channels
//   err_clr      clears err_latched (level, sampled every cycle)
//   quad_ctl     registered event code: 00 HOLD, 01 UP, 10 DOWN, 11 ERROR
//   err_latched  registered sticky error flag (tied 0 when feature is off)
module quad_decoder #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_in,
  input  logic       b_in,
  input  logic       err_clr,
  output logic [1:0] quad_ctl,
  output logic       err_latched
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  localparam logic [1:0] Q_HOLD = 2'b00;
  localparam logic [1:0] Q_UP   = 2'b01;
  localparam logic [1:0] Q_DOWN = 2'b10;
  localparam logic [1:0] Q_ERR  = 2'b11;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t        state;
  logic [1:0]    init_cnt;
  logic [1:0]    sync_a;
  logic [1:0]    sync_b;
  logic          db_a;
  logic          db_b;
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;
  logic [1:0]    prev;

  logic          db_a_nxt;
  logic          db_b_nxt;
  logic [CW-1:0] cnt_a_nxt;
  logic [CW-1:0] cnt_b_nxt;
  logic [1:0]    ctl_c;

  // Debounce step: accept s after DB_CYCLES consecutive disagreeing samples
  function automatic logic [CW:0] deb_step(input logic s, input logic d,
                                           input logic [CW-1:0] c);
    logic [CW:0] r;
    r = {d, {CW{1'b0}}};
    if (s != d) begin
      if (c == CNT_LAST) r = {s, {CW{1'b0}}};
      else               r = {d, c + CW'(1)};
    end
    return r;
  endfunction

  // Gray decode; forward order is 00 -> 01 -> 11 -> 10 -> 00
  function automatic logic [1:0] decode(input logic [1:0] p, input logic [1:0] c);
    logic [1:0] r;
    if (p == c)                 r = Q_HOLD;
    else if ((p ^ c) == 2'b11)  r = Q_ERR;
    else if (c == {p[0], ~p[1]}) r = Q_UP;
    else                        r = Q_DOWN;
    return r;
  endfunction

  always_comb begin
    {db_a_nxt, cnt_a_nxt} = deb_step(sync_a[1], db_a, cnt_a);
    {db_b_nxt, cnt_b_nxt} = deb_step(sync_b[1], db_b, cnt_b);
    ctl_c                 = decode(prev, {db_a, db_b});
  end

  // Sync, debounce, phase tracking and INIT/RUN sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_INIT;
      init_cnt <= 2'd0;
      sync_a   <= 2'b00;
      sync_b   <= 2'b00;
      db_a     <= 1'b0;
      db_b     <= 1'b0;
      cnt_a    <= '0;
      cnt_b    <= '0;
      prev     <= 2'b00;
      quad_ctl <= Q_HOLD;
    end else begin
      sync_a <= {sync_a[0], a_in};
      sync_b <= {sync_b[0], b_in};
      prev   <= {db_a, db_b};
      case (state)
        S_INIT: begin
          // Seed the phase straight from the synchronized levels
          db_a     <= sync_a[1];
          db_b     <= sync_b[1];
          cnt_a    <= '0;
          cnt_b    <= '0;
          quad_ctl <= Q_HOLD;
          init_cnt <= init_cnt + 2'd1;
          if (init_cnt == 2'd3) state <= S_RUN;
        end
        default: begin
          db_a     <= db_a_nxt;
          db_b     <= db_b_nxt;
          cnt_a    <= cnt_a_nxt;
          cnt_b    <= cnt_b_nxt;
          quad_ctl <= ctl_c;
        end
      endcase
    end
  end

`ifdef QUAD_ERR_STICKY_EN
  // Sticky error: set on the edge ERROR is registered, set beats clear
  always_ff @(posedge clk) begin
    if (rst)                                 err_latched <= 1'b0;
    else if (state == S_RUN && ctl_c == Q_ERR) err_latched <= 1'b1;
    else if (err_clr)                        err_latched <= 1'b0;
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_latched    = 1'b0;
`endif

endmodule

// File: tb/tb_quad_decoder.sv
module tb_quad_decoder;
  localparam int unsigned DB   = 4;
  localparam int          NMAX = 8192;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_in = 1'b0;
  logic       b_in = 1'b0;
  logic       err_clr = 1'b0;
  logic [1:0] quad_ctl;
  logic       err_latched;

  quad_decoder #(.DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .err_clr(err_clr),
    .quad_ctl(quad_ctl), .err_latched(err_latched)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] q; logic e; } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int n_up  = 0;
  int n_dn  = 0;
  int n_er  = 0;

  // Reference model: per-edge histories of channel levels
  logic a1 [NMAX];
  logic b1 [NMAX];
  logic a2 [NMAX];
  logic b2 [NMAX];
  logic da [NMAX];
  logic dbv[NMAX];
  int   k         = 2;
  int   init_left = 4;
  int   run_from  = 0;
  logic m_err     = 1'b0;

  initial begin
    for (int i = 0; i < NMAX; i++) begin
      a1[i] = 0; b1[i] = 0; a2[i] = 0; b2[i] = 0; da[i] = 0; dbv[i] = 0;
    end
  end

  function automatic int pos(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] classify(input logic [1:0] p, input logic [1:0] c);
    int d;
    if (p == c) return 2'b00;
    if ((p ^ c) == 2'b11) return 2'b11;
    d = (pos(c) - pos(p) + 4) % 4;
    return (d == 1) ? 2'b01 : 2'b10;
  endfunction

  // Model the edge that will sample these inputs; push the expected outputs
  task automatic model_step(input logic r, input logic ia, input logic ib, input logic ic);
    logic [1:0] q;
    logic ok_a, ok_b;
    exp_t e;
    if (r) begin
      a1[k] = 0; b1[k] = 0; a2[k] = 0; b2[k] = 0; da[k] = 0; dbv[k] = 0;
      q = 2'b00; init_left = 4; m_err = 1'b0;
    end else begin
      a1[k] = ia; b1[k] = ib;
      a2[k] = a1[k-1]; b2[k] = b1[k-1];
      if (init_left > 0) begin
        da[k] = a2[k-1]; dbv[k] = b2[k-1]; q = 2'b00;
        init_left--;
        if (init_left == 0) run_from = k + 1;
      end else begin
        ok_a = (k - int'(DB) + 1 >= run_from);
        ok_b = ok_a;
        for (int i = 0; i < int'(DB); i++) begin
          if (a2[k-1-i] == da[k-1])  ok_a = 1'b0;
          if (b2[k-1-i] == dbv[k-1]) ok_b = 1'b0;
        end
        da[k]  = ok_a ? ~da[k-1]  : da[k-1];
        dbv[k] = ok_b ? ~dbv[k-1] : dbv[k-1];
        q = classify({da[k-2], dbv[k-2]}, {da[k-1], dbv[k-1]});
      end
`ifdef QUAD_ERR_STICKY_EN
      if (q == 2'b11) m_err = 1'b1;
      else if (ic)    m_err = 1'b0;
`else
      m_err = 1'b0;
`endif
    end
    e.q = q; e.e = m_err;
    exp_q.push_back(e);
    k++;
  endtask

  task automatic cyc(input logic r, input logic ia, input logic ib, input logic ic);
    @(negedge clk);
    rst = r; a_in = ia; b_in = ib; err_clr = ic;
    model_step(r, ia, ib, ic);
  endtask

  task automatic hold(input int n, input logic ia, input logic ib);
    for (int i = 0; i < n; i++) cyc(1'b0, ia, ib, 1'b0);
  endtask

  task automatic do_reset(input logic ia, input logic ib);
    for (int i = 0; i < 3; i++) cyc(1'b1, ia, ib, 1'b0);
  endtask

  // Monitor: compare every cycle against the scoreboard
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (quad_ctl !== e.q) begin
        bad++;
        $display("FAIL quad_ctl t=%0t got=%b exp=%b", $time, quad_ctl, e.q);
      end
      total++;
      if (err_latched !== e.e) begin
        bad++;
        $display("FAIL err_latched t=%0t got=%b exp=%b", $time, err_latched, e.e);
      end
      if (quad_ctl === 2'b01) n_up++;
      if (quad_ctl === 2'b10) n_dn++;
      if (quad_ctl === 2'b11) n_er++;
    end
  end

  int su, sd, se;
  task automatic snap();
    su = n_up; sd = n_dn; se = n_er;
  endtask

  task automatic check_events(input string name, input int eu, input int ed, input int ee);
    total++;
    if (n_up - su != eu || n_dn - sd != ed || n_er - se != ee) begin
      bad++;
      $display("FAIL %s events got up=%0d dn=%0d err=%0d exp up=%0d dn=%0d err=%0d",
               name, n_up - su, n_dn - sd, n_er - se, eu, ed, ee);
    end
  endtask

  initial begin
    logic ra, rb, rc, rr;
    int dur;
    do_reset(1'b0, 1'b0);
    hold(12, 1'b0, 1'b0);

    snap();
    hold(10, 1'b0, 1'b1); hold(10, 1'b1, 1'b1); hold(10, 1'b1, 1'b0); hold(10, 1'b0, 1'b0);
    hold(4, 1'b0, 1'b0);
    check_events("forward", 4, 0, 0);

    snap();
    hold(10, 1'b1, 1'b0); hold(10, 1'b1, 1'b1); hold(10, 1'b0, 1'b1); hold(10, 1'b0, 1'b0);
    hold(4, 1'b0, 1'b0);
    check_events("reverse", 0, 4, 0);

    snap();
    hold(3, 1'b1, 1'b0); hold(12, 1'b0, 1'b0);
    check_events("glitch3", 0, 0, 0);

    snap();
    hold(4, 1'b1, 1'b0); hold(12, 1'b0, 1'b0);
    check_events("glitch4", 1, 1, 0);

    snap();
    hold(12, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    hold(5, 1'b1, 1'b1);
    hold(12, 1'b0, 1'b0);
    hold(3, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    hold(3, 1'b0, 1'b0);
    check_events("simultaneous", 0, 0, 2);

    snap();
    do_reset(1'b1, 1'b1);
    hold(12, 1'b1, 1'b1);
    check_events("reset_high", 0, 0, 0);
    snap();
    hold(12, 1'b1, 1'b0);
    check_events("after_reset_step", 1, 0, 0);

    do_reset(1'b0, 1'b0);
    hold(12, 1'b0, 1'b0);
    snap();
    hold(4, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    hold(12, 1'b1, 1'b0);
    check_events("reset_mid_debounce", 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      ra  = 1'($urandom_range(0, 1));
      rb  = 1'($urandom_range(0, 1));
      dur = int'($urandom_range(1, 12));
      rr  = ($urandom_range(0, 99) < 2);
      for (int i = 0; i < dur; i++) begin
        rc = ($urandom_range(0, 7) == 0);
        cyc((i == 0) ? rr : 1'b0, ra, rb, rc);
      end
    end

    hold(3, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
